regfile_mp_sb: RTL and testbench

//  Parametrised multi-port integer register file with a per-register busy scoreboard.

---
 rtl/regfile_mp_sb_if.sv | 27 ++
 rtl/regfile_mp_sb.sv | 66 ++++++
 tb/tb_regfile_mp_sb.sv | 128 ++++++++++++
 3 files changed

// File: rtl/regfile_mp_sb_if.sv
// regfile_mp_sb_if: read, writeback and reserve bundle for the register file.
interface regfile_mp_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  parameter int AW   = $clog2(NREG)
);
  logic [NRD-1:0]      rd_en_i;
  logic [NRD*AW-1:0]   rd_addr_i;
  logic [NRD*XLEN-1:0] rd_data_o;
  logic [NRD-1:0]      rd_ready_o;
  logic [NWR-1:0]      wr_en_i;
  logic [NWR*AW-1:0]   wr_addr_i;
  logic [NWR*XLEN-1:0] wr_data_i;
  logic                rsv_en_i;
  logic [AW-1:0]       rsv_addr_i;
  logic [NREG-1:0]     busy_vec_o;
  modport master (
    output rd_en_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, rsv_en_i, rsv_addr_i,
    input  rd_data_o, rd_ready_o, busy_vec_o
  );
  modport slave (
    input  rd_en_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, rsv_en_i, rsv_addr_i,
    output rd_data_o, rd_ready_o, busy_vec_o
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with busy scoreboard and write-to-read bypass.
module regfile_mp_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = (NREG > 1) ? $clog2(NREG) : 1
) (
  input logic             CLK,
  input logic             RST,
  regfile_mp_sb_if.slave  bus
);
  localparam int DEPTH = 1 << AW;
  logic [XLEN-1:0]  regs_q [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] live;
  logic [AW-1:0]    wa [NWR];
  logic [XLEN-1:0]  wd [NWR];
  logic [NWR-1:0]   wv;
  logic [AW-1:0]    ra [NRD];
  // live marks addresses that really hold state: in range and not the hard-wired zero
  for (genvar i = 0; i < DEPTH; i++) begin : g_live
    assign live[i] = (i < NREG) && !(ZERO_REG != 0 && i == 0);
  end
  always_comb begin
    for (int w = 0; w < NWR; w++) begin
      wa[w] = bus.wr_addr_i[w*AW +: AW];
      wd[w] = bus.wr_data_i[w*XLEN +: XLEN];
      wv[w] = bus.wr_en_i[w] && live[wa[w]];
    end
    for (int p = 0; p < NRD; p++) ra[p] = bus.rd_addr_i[p*AW +: AW];
  end
  always_comb begin
    bus.rd_data_o  = '0;
    bus.rd_ready_o = '1;
    for (int p = 0; p < NRD; p++) begin
      if (!RST && bus.rd_en_i[p] && live[ra[p]]) begin
        bus.rd_data_o[p*XLEN +: XLEN] = regs_q[ra[p]];
        bus.rd_ready_o[p]             = ~busy_q[ra[p]];
        for (int w = 0; w < NWR; w++) begin
          if (wv[w] && wa[w] == ra[p]) begin
            bus.rd_data_o[p*XLEN +: XLEN] = wd[w];
            bus.rd_ready_o[p]             = 1'b1;
          end
        end
      end
    end
  end
  assign bus.busy_vec_o = busy_q[NREG-1:0];
  // later ports overwrite earlier ones; a reserve is applied last so it beats a clear
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wv[w]) begin
          regs_q[wa[w]] <= wd[w];
          busy_q[wa[w]] <= 1'b0;
        end
      end
      if (bus.rsv_en_i && live[bus.rsv_addr_i]) busy_q[bus.rsv_addr_i] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: scoreboard bench with a behavioural register-file model and random traffic.
module tb_regfile_mp_sb;
  localparam int XLEN = 32, NREG = 32, NRD = 2, NWR = 2, AW = 5;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;
  regfile_mp_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .AW(AW)) bus ();
  regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );
  typedef struct {
    int          tag;
    logic [63:0] d;
    logic [1:0]  r;
    logic [31:0] b;
  } exp_t;
  exp_t        q[$];
  logic [31:0] m_reg [32];
  logic [31:0] m_busy;
  int          vecs = 0;
  int          bad = 0;
  task automatic step(input bit r, input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1,
                      input logic [1:0] we, input logic [4:0] w0, input logic [31:0] d0,
                      input logic [4:0] w1, input logic [31:0] d1,
                      input bit rv, input logic [4:0] rsa, input int tag);
    exp_t        e;
    logic [4:0]  rad [2];
    logic [4:0]  wad [2];
    logic [31:0] wdt [2];
    logic [31:0] dd;
    logic        rr;
    rad[0] = a0; rad[1] = a1; wad[0] = w0; wad[1] = w1; wdt[0] = d0; wdt[1] = d1;
    @(posedge CLK);
    #1;
    RST = r;
    bus.rd_en_i = re; bus.rd_addr_i = {a1, a0};
    bus.wr_en_i = we; bus.wr_addr_i = {w1, w0}; bus.wr_data_i = {d1, d0};
    bus.rsv_en_i = rv; bus.rsv_addr_i = rsa;
    if (r) begin
      for (int i = 0; i < 32; i++) m_reg[i] = '0;
      m_busy = '0;
    end
    e.tag = tag;
    e.b = m_busy;
    for (int p = 0; p < 2; p++) begin
      dd = '0;
      rr = 1'b1;
      if (!r && re[p] && rad[p] != 0) begin
        dd = m_reg[rad[p]];
        rr = !m_busy[rad[p]];
        for (int w = 1; w >= 0; w--) begin
          if (we[w] && wad[w] != 0 && wad[w] == rad[p]) begin
            dd = wdt[w];
            rr = 1'b1;
            break;
          end
        end
      end
      e.d[p*32 +: 32] = dd;
      e.r[p] = rr;
    end
    q.push_back(e);
    if (!r) begin
      for (int w = 0; w < 2; w++) begin
        if (we[w] && wad[w] != 0) begin
          m_reg[wad[w]] = wdt[w];
          m_busy[wad[w]] = 1'b0;
        end
      end
      if (rv && rsa != 0) m_busy[rsa] = 1'b1;
    end
  endtask
  always @(negedge CLK) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      vecs++;
      if (bus.rd_data_o !== e.d) begin
        bad++;
        $display("FAIL tag=%0d rd_data got %h expected %h", e.tag, bus.rd_data_o, e.d);
      end
      vecs++;
      if (bus.rd_ready_o !== e.r) begin
        bad++;
        $display("FAIL tag=%0d rd_ready got %b expected %b", e.tag, bus.rd_ready_o, e.r);
      end
      vecs++;
      if (bus.busy_vec_o !== e.b) begin
        bad++;
        $display("FAIL tag=%0d busy_vec got %h expected %h", e.tag, bus.busy_vec_o, e.b);
      end
    end
  end
  initial begin
    step(1, 2'b11, 5'd5, 5'd0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    step(0, 2'b01, 5'd5, 5'd0, 2'b01, 5'd5, 32'hDEAD, 0, 0, 0, 0, 2);
    step(0, 2'b11, 5'd5, 5'd5, 2'b00, 0, 0, 0, 0, 0, 0, 3);
    step(1, 2'b11, 5'd5, 5'd5, 2'b01, 5'd5, 32'hBEEF, 0, 0, 1, 5'd6, 4);
    step(0, 2'b11, 5'd5, 5'd5, 2'b00, 0, 0, 0, 0, 0, 0, 5);
    step(0, 2'b01, 5'd7, 5'd0, 2'b01, 5'd7, 32'h1234, 0, 0, 0, 0, 6);
    step(0, 2'b01, 5'd7, 5'd0, 2'b00, 0, 0, 0, 0, 0, 0, 7);
    step(0, 2'b10, 5'd0, 5'd0, 2'b01, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 8);
    step(0, 2'b11, 5'd0, 5'd0, 2'b00, 0, 0, 0, 0, 1, 5'd0, 9);
    step(0, 2'b11, 5'd0, 5'd0, 2'b00, 0, 0, 0, 0, 1, 5'd3, 10);
    step(0, 2'b01, 5'd3, 5'd0, 2'b00, 0, 0, 0, 0, 0, 0, 11);
    step(0, 2'b11, 5'd3, 5'd3, 2'b10, 0, 0, 5'd3, 32'h55, 0, 0, 12);
    step(0, 2'b01, 5'd3, 5'd0, 2'b00, 0, 0, 0, 0, 0, 0, 13);
    step(0, 2'b11, 5'd9, 5'd9, 2'b11, 5'd9, 32'hA, 5'd9, 32'hB, 0, 0, 14);
    step(0, 2'b11, 5'd9, 5'd9, 2'b00, 0, 0, 0, 0, 0, 0, 15);
    step(0, 2'b00, 0, 0, 2'b01, 5'd4, 32'h44, 0, 0, 1, 5'd4, 16);
    step(0, 2'b10, 0, 5'd4, 2'b00, 0, 0, 0, 0, 0, 0, 17);
    step(0, 2'b10, 0, 5'd4, 2'b10, 0, 0, 5'd4, 32'h45, 0, 0, 18);
    for (int n = 0; n < 400; n++)
      step(0, 2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           2'($urandom), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)), 100 + n);
    step(1, 2'b11, 5'd1, 5'd2, 2'b00, 0, 0, 0, 0, 0, 0, 600);
    repeat (3) @(negedge CLK);
    vecs++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending got %0d expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end
endmodule
